fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline. Owns the PC,
//  drives the icache request, and applies the hazard unit's hazard/branch/jump verdicts: stall,
//  flush and redirect. Output feeds the decode stage; hazard unit decisions are consumed here.
// PARAMETERS
//  PC_INIT  32'h0000_0000  PC value loaded on reset
// PORTS
//  CLK            in   1   clock, rising edge
//  nRST           in   1   reset, asynchronous, active-low
//  ihit           in   1   icache: iload valid for imemaddr this cycle
//  iload          in   32  icache: fetched instruction
//  imemREN        out  1   icache read request
//  imemaddr       out  32  icache address (word aligned)
//  hazard         in   1   hazard unit: hold IF/ID and PC (load-use)
//  branch         in   1   hazard unit: taken branch resolved in ID
//  jump           in   1   hazard unit: J/JAL/JR in ID
//  branch_target  in   32  ID-computed branch target
//  jump_target    in   32  ID-computed jump/JR target
//  halt           in   1   HALT decoded in ID
//  id_instr       out  32  IF/ID: instruction (0 = bubble)
//  id_npc         out  32  IF/ID: fetch PC + 4
//  id_valid       out  1   IF/ID: entry holds a real instruction
// BEHAVIOUR
//  Reset (async, nRST=0): pc=PC_INIT, id_instr=0, id_npc=0, id_valid=0, state=RUN, redir_pc=0.
//  imemaddr = {pc[31:2],2'b00}; imemREN = (state != HALTED). Both combinational from registers.
//  Redirect target: jump ? jump_target : branch_target (jump wins if both). redirect = branch|jump.
//  Per-cycle priority in RUN: halt > hazard > redirect > ihit > miss.
//   halt: state<=HALTED, IF/ID<=bubble, pc held. Sticky until reset.
//   hazard: pc and IF/ID hold; branch/jump ignored this cycle (ID re-evaluates next cycle).
//   redirect & ihit: pc<=target, IF/ID<=bubble (wrong-path fetch dropped). 1-cycle penalty.
//   redirect & !ihit: redir_pc<=target, IF/ID<=bubble, pc held (address stable for cache), ->PENDING.
//   ihit: pc<=pc+4, IF/ID<={iload, pc+4, valid=1}.
//   !ihit: pc held, IF/ID<=bubble (decode keeps draining).
//  PENDING: imemaddr stays at old pc until ihit; returned data discarded.
//   ihit: pc<=redir_pc, state<=RUN, IF/ID bubble. !ihit: wait, IF/ID bubble.
//   new redirect in PENDING: redir_pc overwritten (latest wins). hazard in PENDING: IF/ID holds.
//   halt in PENDING: -> HALTED, pending redirect discarded.
//  HALTED: imemREN=0, pc and IF/ID bubble frozen; all inputs ignored.
//  Arithmetic: pc+4 modulo 2^32 (32'hFFFF_FFFC -> 0); targets taken with bits[1:0] forced 0.
//  Bubble = {instr=0 (sll $0 nop), npc=0, valid=0}.
//  Reset mid-miss or mid-PENDING: immediate return to reset state; no cache handshake preserved.
// STRUCTURE
//  cpu_types_pkg: word_t (32b), fetch_state_t enum {RUN, PENDING, HALTED}, WORD_BYTES=4.
//  Sub-module if_id_latch: IF/ID register with hold(hazard)/flush(bubble)/load controls, own
//  async nRST; fetch_stage holds PC, redir_pc, FSM and next-PC mux.
// TESTING
//  Straight-line: ihit=1 every cycle, PC_INIT=0 -> imemaddr 0,4,8,..; id_npc = addr+4, valid=1.
//  Miss: ihit low 3 cycles at pc=8 -> imemaddr held 8, id_valid=0 x3, then id_instr=iload@8.
//  Load-use: hazard=1 two cycles with branch=1 -> pc and id_instr unchanged, no redirect taken.
//  Redirect+hit: branch=1,target=0x40,ihit=1 -> next imemaddr=0x40, id_valid=0 one cycle.
//  Redirect+miss: jump=1,target=0x80,ihit=0 at pc=0x10 -> addr stays 0x10 until ihit, data
//   dropped, then imemaddr=0x80; jump+branch same cycle -> jump_target used.
//  Halt/reset: halt=1 -> imemREN=0, IF/ID frozen bubble; nRST low mid-PENDING -> pc=PC_INIT, RUN.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline front end: the machine word, the fetch FSM states
// and the fetch stride.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PENDING = 2'd1,
        HALTED  = 2'd2
    } fetch_state_t;

    localparam word_t WORD_BYTES = 32'd4;

endpackage

// File: rtl/if_id_latch.sv
// IF/ID pipeline register. Hold has priority over flush, and flush over load.
// With none of the three asserted, the register keeps its contents.
module if_id_latch
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  hold,
    input  logic  flush,
    input  logic  load,
    input  word_t instr_in,
    input  word_t npc_in,
    output word_t instr_out,
    output word_t npc_out,
    output logic  valid_out
);

    word_t instr_q, instr_d;
    word_t npc_q, npc_d;
    logic  valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        npc_d   = npc_q;
        valid_d = valid_q;
        if (hold) begin
            instr_d = instr_q;
        end else if (flush) begin
            instr_d = '0;
            npc_d   = '0;
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = instr_in;
            npc_d   = npc_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr_q <= '0;
            npc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_out = instr_q;
    assign npc_out   = npc_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the icache, and applies stall, flush and
// redirect verdicts from the hazard unit before filling the IF/ID register.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  ihit,
    input  word_t iload,
    output logic  imemREN,
    output word_t imemaddr,
    input  logic  hazard,
    input  logic  branch,
    input  logic  jump,
    input  word_t branch_target,
    input  word_t jump_target,
    input  logic  halt,
    output word_t id_instr,
    output word_t id_npc,
    output logic  id_valid
);

    word_t        pc_q, pc_d;
    word_t        redir_pc_q, redir_pc_d;
    fetch_state_t state_q, state_d;

    logic  ifid_hold, ifid_flush, ifid_load;
    logic  redirect;
    word_t target;
    word_t pc_plus4;

    assign redirect = branch | jump;
    assign target   = (jump ? jump_target : branch_target) & ~32'h3;
    assign pc_plus4 = pc_q + WORD_BYTES;

    always_comb begin
        pc_d       = pc_q;
        redir_pc_d = redir_pc_q;
        state_d    = state_q;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        ifid_load  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (halt) begin
                    state_d    = HALTED;
                    ifid_flush = 1'b1;
                end else if (hazard) begin
                    ifid_hold = 1'b1;
                end else if (redirect) begin
                    ifid_flush = 1'b1;
                    if (ihit) begin
                        pc_d = target;
                    end else begin
                        // Keep pc so the cache sees a stable address until it answers.
                        redir_pc_d = target;
                        state_d    = PENDING;
                    end
                end else if (ihit) begin
                    ifid_load = 1'b1;
                    pc_d      = pc_plus4;
                end else begin
                    ifid_flush = 1'b1;
                end
            end
            PENDING: begin
                if (halt) begin
                    state_d    = HALTED;
                    redir_pc_d = '0;
                    ifid_flush = 1'b1;
                end else if (hazard) begin
                    ifid_hold = 1'b1;
                end else if (redirect) begin
                    ifid_flush = 1'b1;
                    if (ihit) begin
                        pc_d    = target;
                        state_d = RUN;
                    end else begin
                        redir_pc_d = target;
                    end
                end else if (ihit) begin
                    // Wrong-path data returned; drop it and take the saved target.
                    pc_d       = redir_pc_q;
                    state_d    = RUN;
                    ifid_flush = 1'b1;
                end else begin
                    ifid_flush = 1'b1;
                end
            end
            HALTED: begin
                ifid_hold = 1'b1;
            end
            default: begin
                state_d   = HALTED;
                ifid_hold = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q       <= PC_INIT;
            redir_pc_q <= '0;
            state_q    <= RUN;
        end else begin
            pc_q       <= pc_d;
            redir_pc_q <= redir_pc_d;
            state_q    <= state_d;
        end
    end

    assign imemaddr = pc_q & ~32'h3;
    assign imemREN  = (state_q != HALTED);

    if_id_latch u_if_id (
        .CLK       (CLK),
        .nRST      (nRST),
        .hold      (ifid_hold),
        .flush     (ifid_flush),
        .load      (ifid_load),
        .instr_in  (iload),
        .npc_in    (pc_plus4),
        .instr_out (id_instr),
        .npc_out   (id_npc),
        .valid_out (id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a behavioural model of the fetch rules.
module tb_fetch_stage;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST = 1'b0;
    logic  ihit = 1'b0;
    word_t iload = '0;
    logic  imemREN;
    word_t imemaddr;
    logic  hazard = 1'b0;
    logic  branch = 1'b0;
    logic  jump = 1'b0;
    word_t branch_target = '0;
    word_t jump_target = '0;
    logic  halt = 1'b0;
    word_t id_instr;
    word_t id_npc;
    logic  id_valid;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .ihit          (ihit),
        .iload         (iload),
        .imemREN       (imemREN),
        .imemaddr      (imemaddr),
        .hazard        (hazard),
        .branch        (branch),
        .jump          (jump),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .halt          (halt),
        .id_instr      (id_instr),
        .id_npc        (id_npc),
        .id_valid      (id_valid)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: where fetch is, whether a redirect is waiting on the cache,
    // whether the machine has halted, and what decode currently holds.
    word_t m_pc, m_waiting_target, m_instr, m_npc;
    logic  m_valid, m_waiting, m_halted;

    always @(posedge CLK or negedge nRST) begin
        word_t tgt;
        if (!nRST) begin
            m_pc = 32'h0; m_waiting_target = '0; m_waiting = 1'b0; m_halted = 1'b0;
            m_instr = '0; m_npc = '0; m_valid = 1'b0;
        end else if (!m_halted) begin
            tgt = jump ? jump_target : branch_target;
            tgt[1:0] = 2'b00;
            if (halt) begin
                m_halted = 1'b1;
                m_instr = '0; m_npc = '0; m_valid = 1'b0;
            end else if (hazard) begin
                // decode stalls: nothing moves
            end else begin
                // Every case except a fresh in-order hit leaves a bubble in decode.
                m_instr = '0; m_npc = '0; m_valid = 1'b0;
                if (branch || jump) begin
                    if (ihit) begin
                        m_pc = tgt; m_waiting = 1'b0;
                    end else begin
                        m_waiting_target = tgt; m_waiting = 1'b1;
                    end
                end else if (ihit && m_waiting) begin
                    m_pc = m_waiting_target; m_waiting = 1'b0;
                end else if (ihit) begin
                    m_instr = iload; m_npc = m_pc + 32'd4; m_valid = 1'b1;
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    task automatic check(input string name, input word_t act, input word_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            check("model imemREN", {31'd0, imemREN}, {31'd0, !m_halted});
            check("model imemaddr", imemaddr, {m_pc[31:2], 2'b00});
            check("model id_instr", id_instr, m_instr);
            check("model id_npc", id_npc, m_npc);
            check("model id_valid", {31'd0, id_valid}, {31'd0, m_valid});
        end
    end

    task automatic step(input logic h, input logic hz, input logic br, input logic jp,
                        input word_t bt, input word_t jt, input logic hit);
        halt = h; hazard = hz; branch = br; jump = jp;
        branch_target = bt; jump_target = jt; ihit = hit;
        iload = 32'hA000_0000 + m_pc;
        @(negedge CLK);
    endtask

    initial begin
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        check("reset imemaddr", imemaddr, 32'h0);
        check("reset imemREN", {31'd0, imemREN}, 32'd1);
        check("reset id_valid", {31'd0, id_valid}, 32'd0);
        check("reset id_instr", id_instr, 32'h0);

        // Straight-line fetch
        step(0, 0, 0, 0, 0, 0, 1);
        check("seq0 id_instr", id_instr, 32'hA000_0000);
        check("seq0 id_npc", id_npc, 32'h4);
        check("seq0 imemaddr", imemaddr, 32'h4);
        step(0, 0, 0, 0, 0, 0, 1);
        check("seq1 id_npc", id_npc, 32'h8);
        check("seq1 imemaddr", imemaddr, 32'h8);

        // Three-cycle miss at pc=8
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            check("miss imemaddr", imemaddr, 32'h8);
            check("miss id_valid", {31'd0, id_valid}, 32'd0);
        end
        step(0, 0, 0, 0, 0, 0, 1);
        check("miss-end id_instr", id_instr, 32'hA000_0008);
        check("miss-end id_npc", id_npc, 32'hC);

        // Load-use stall with a branch that must be ignored
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 1, 0, 32'h40, 0, 1);
            check("hazard imemaddr", imemaddr, 32'hC);
            check("hazard id_instr", id_instr, 32'hA000_0008);
            check("hazard id_valid", {31'd0, id_valid}, 32'd1);
        end

        // Redirect with hit
        step(0, 0, 1, 0, 32'h40, 0, 1);
        check("br-hit imemaddr", imemaddr, 32'h40);
        check("br-hit id_valid", {31'd0, id_valid}, 32'd0);
        step(0, 0, 0, 1, 0, 32'h13, 1);
        check("jmp-hit masked imemaddr", imemaddr, 32'h10);

        // Redirect with miss; jump wins over branch
        step(0, 0, 1, 1, 32'h200, 32'h80, 0);
        check("pend imemaddr", imemaddr, 32'h10);
        check("pend id_valid", {31'd0, id_valid}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("pend wait imemaddr", imemaddr, 32'h10);
        step(0, 0, 0, 0, 0, 0, 1);
        check("pend done imemaddr", imemaddr, 32'h80);
        check("pend done id_valid", {31'd0, id_valid}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 1);
        check("post-pend id_instr", id_instr, 32'hA000_0080);
        check("post-pend id_npc", id_npc, 32'h84);

        // Reset in the middle of PENDING
        step(0, 0, 0, 1, 0, 32'h100, 0);
        check("pend2 imemaddr", imemaddr, 32'h84);
        jump = 1'b0; ihit = 1'b0;
        #2 nRST = 1'b0;
        #1;
        check("midreset imemaddr", imemaddr, 32'h0);
        check("midreset id_valid", {31'd0, id_valid}, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        step(0, 0, 0, 0, 0, 0, 1);
        check("after reset imemaddr", imemaddr, 32'h4);
        check("after reset id_npc", id_npc, 32'h4);

        // Halt is sticky and freezes everything
        step(1, 0, 0, 0, 0, 0, 1);
        check("halt imemREN", {31'd0, imemREN}, 32'd0);
        check("halt id_valid", {31'd0, id_valid}, 32'd0);
        step(0, 0, 0, 1, 0, 32'h400, 1);
        check("halted imemaddr", imemaddr, 32'h4);
        check("halted imemREN", {31'd0, imemREN}, 32'd0);

        // PC wrap at the top of the address space
        nRST = 1'b0;
        #2 nRST = 1'b1;
        step(0, 0, 0, 1, 0, 32'hFFFF_FFFC, 1);
        check("wrap pre imemaddr", imemaddr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 0, 1);
        check("wrap imemaddr", imemaddr, 32'h0);
        check("wrap id_npc", id_npc, 32'h0);

        // Random phase
        for (int i = 0; i < 4000; i++) begin
            if (($urandom_range(0, 499) == 0) || (m_halted && $urandom_range(0, 19) == 0)) begin
                nRST = 1'b0;
                #2 nRST = 1'b1;
            end
            halt          = ($urandom_range(0, 399) == 0);
            hazard        = ($urandom_range(0, 99) < 15);
            branch        = ($urandom_range(0, 99) < 10);
            jump          = ($urandom_range(0, 99) < 10);
            branch_target = $urandom;
            jump_target   = $urandom;
            ihit          = ($urandom_range(0, 99) < 70);
            iload         = $urandom;
            @(negedge CLK);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
